core_bus_arbiter: RTL and testbench

- Sits directly downstream of the core's instruction-fetch (ibus) and data (dbus) request ports.
- Serializes the two request streams onto one single-beat memory port, with at most one outstanding transaction.
- Returns the response, with the addr_ok/data_ok handshake, to whichever requester was granted.
- Includes a response watchdog that flags a hung memory port.

---
 rtl/core_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_core_bus_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter that serializes core fetch and data requests onto one
// single-beat memory port, with a sticky watchdog on the response wait.
module core_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [31:0]       i_data,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [7:0]        d_strobe,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [7:0]        m_strobe,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_e;
    typedef enum logic {GNT_I, GNT_D} grant_e;

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    grant_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [7:0]        strobe_q, strobe_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hi_sel_q, hi_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              err_q, err_d;
    logic              pick_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= GNT_I;
            // Seeded so that the first contested arbitration goes to data.
            last_grant_q <= GNT_I;
            addr_q       <= '0;
            size_q       <= '0;
            strobe_q     <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            hi_sel_q     <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            strobe_q     <= strobe_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            hi_sel_q     <= hi_sel_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        size_d       = size_q;
        strobe_d     = strobe_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        hi_sel_d     = hi_sel_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        cnt_inc      = cnt_q + 1'b1;
        pick_d       = d_valid && (!i_valid || (last_grant_q == GNT_I));

        case (state_q)
            IDLE: begin
                if (d_valid || i_valid) begin
                    grant_d      = pick_d ? GNT_D : GNT_I;
                    last_grant_d = pick_d ? GNT_D : GNT_I;
                    state_d      = REQ;
                    if (pick_d) begin
                        addr_d   = d_addr;
                        size_d   = d_size;
                        strobe_d = d_strobe;
                        wdata_d  = d_wdata;
                    end else begin
                        addr_d   = i_addr;
                        size_d   = 3'b010;
                        strobe_d = 8'h00;
                        wdata_d  = '0;
                    end
                end
            end
            REQ: begin
                if (m_ready) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (m_rvalid) begin
                    rdata_d  = m_rdata;
                    // Half-select frozen here so i_data holds after the next grant.
                    hi_sel_d = addr_q[2];
                    cnt_d    = '0;
                    state_d  = DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_inc;
                    if ((TIMEOUT != 0) && (cnt_inc == CNT_MAX)) begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_valid   = (state_q == REQ);
    assign m_addr    = addr_q;
    assign m_size    = size_q;
    assign m_strobe  = strobe_q;
    assign m_wdata   = wdata_q;

    assign i_addr_ok = (state_q == DONE) && (grant_q == GNT_I);
    assign i_data_ok = (state_q == DONE) && (grant_q == GNT_I);
    assign d_addr_ok = (state_q == DONE) && (grant_q == GNT_D);
    assign d_data_ok = (state_q == DONE) && (grant_q == GNT_D);

    assign i_data    = hi_sel_q ? rdata_q[63:32] : rdata_q[31:0];
    assign d_rdata   = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench for core_bus_arbiter: stimulus pushes expected memory
// requests and port responses; monitors pop and compare as the DUT emits them.
module tb_core_bus_arbiter;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_valid = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_addr_ok, i_data_ok;
    logic [31:0]       i_data;
    logic              d_valid = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [2:0]        d_size = '0;
    logic [7:0]        d_strobe = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_addr_ok, d_data_ok;
    logic [DATA_W-1:0] d_rdata;
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [2:0]        m_size;
    logic [7:0]        m_strobe;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready = 1'b0;
    logic              m_rvalid = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              err;

    core_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [240:0] all_out;
    assign all_out = {i_addr_ok, i_data_ok, i_data, d_addr_ok, d_data_ok, d_rdata,
                      m_valid, m_addr, m_size, m_strobe, m_wdata, err};

    typedef struct {
        logic        is_d;
        logic [63:0] data;
        int          start;
        int          lat;
    } resp_t;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] wdata;
        int          len;
    } req_t;

    resp_t       resp_q[$];
    req_t        req_q[$];
    logic [63:0] rd_q[$];

    int tests = 0;
    int fails = 0;
    int ok_count = 0;

    bit mem_en = 1'b0;
    int ready_dly = 0;
    int rvalid_dly = 0;

    // Response monitor
    resp_t       mon_e;
    logic [63:0] mon_got;
    initial forever begin
        @(negedge clk); #1;
        if (i_data_ok || d_data_ok) begin
            ok_count++;
            mon_got = d_data_ok ? d_rdata : {32'h0, i_data};
            tests++;
            if (resp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ok: i_data_ok=%0b d_data_ok=%0b at cycle %0d, required no pulse",
                         i_data_ok, d_data_ok, cyc);
            end else begin
                mon_e = resp_q.pop_front();
                if ((i_data_ok && d_data_ok) || (d_data_ok != mon_e.is_d) || (mon_got != mon_e.data) ||
                    (i_addr_ok != i_data_ok) || (d_addr_ok != d_data_ok)) begin
                    fails++;
                    $display("FAIL resp: got d=%0b i_ok=%0b/%0b d_ok=%0b/%0b data=%h, required d=%0b data=%h",
                             d_data_ok, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, mon_got,
                             mon_e.is_d, mon_e.data);
                end
                if (mon_e.lat >= 0) begin
                    tests++;
                    if (cyc - mon_e.start != mon_e.lat) begin
                        fails++;
                        $display("FAIL latency: got %0d cycles, required %0d", cyc - mon_e.start, mon_e.lat);
                    end
                end
            end
        end
    end

    // Memory request monitor: accept checks, hold-stability, watchdog timing
    int   run_len = 0;
    int   acc_cyc = 0;
    logic err_prev = 1'b0;
    req_t prev_r, exp_r;
    initial forever begin
        @(negedge clk); #1;
        if (m_valid) begin
            if (run_len > 0) begin
                tests++;
                if (m_addr != prev_r.addr || m_size != prev_r.size ||
                    m_strobe != prev_r.strobe || m_wdata != prev_r.wdata) begin
                    fails++;
                    $display("FAIL req_stable: got addr=%h size=%0d strb=%h wdata=%h, required addr=%h size=%0d strb=%h wdata=%h",
                             m_addr, m_size, m_strobe, m_wdata, prev_r.addr, prev_r.size, prev_r.strobe, prev_r.wdata);
                end
            end
            run_len++;
            prev_r = '{m_addr, m_size, m_strobe, m_wdata, 0};
            if (m_ready) begin
                acc_cyc = cyc;
                tests++;
                if (req_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_req: addr=%h, required no request", m_addr);
                end else begin
                    exp_r = req_q.pop_front();
                    if (m_addr != exp_r.addr || m_size != exp_r.size || m_strobe != exp_r.strobe ||
                        m_wdata != exp_r.wdata || run_len != exp_r.len) begin
                        fails++;
                        $display("FAIL req: got addr=%h size=%0d strb=%h wdata=%h len=%0d, required addr=%h size=%0d strb=%h wdata=%h len=%0d",
                                 m_addr, m_size, m_strobe, m_wdata, run_len,
                                 exp_r.addr, exp_r.size, exp_r.strobe, exp_r.wdata, exp_r.len);
                    end
                end
                run_len = 0;
            end
        end else begin
            run_len = 0;
        end
        if (err && !err_prev) begin
            tests++;
            if (cyc - acc_cyc - 1 != TIMEOUT) begin
                fails++;
                $display("FAIL wdog_timing: err rose %0d cycles into WAIT_RESP, required %0d",
                         cyc - acc_cyc - 1, TIMEOUT);
            end
        end
        err_prev = err;
    end

    // Memory responder
    initial forever begin
        @(negedge clk);
        if (mem_en && m_valid) begin
            repeat (ready_dly) @(negedge clk);
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
            repeat (rvalid_dly) @(negedge clk);
            m_rvalid = 1'b1;
            m_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 64'h0;
            @(negedge clk);
            m_rvalid = 1'b0;
        end
    end

    task automatic wait_ok(input int target, input int bound, input string name);
        int n = 0;
        while (ok_count < target && n < bound) begin
            @(negedge clk); #2;
            n++;
        end
        tests++;
        if (ok_count < target) begin
            fails++;
            $display("FAIL %s_timeout: ok pulses %0d, required %0d", name, ok_count, target);
        end
    endtask

    initial begin
        #3;
        tests++;
        if (all_out != '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk); #2;
        tests++;
        if (all_out != '0) begin
            fails++;
            $display("FAIL idle_outputs: got %h, required 0", all_out);
        end

        // Fetch only, upper half selected by addr[2]
        mem_en = 1'b1; ready_dly = 0; rvalid_dly = 0;
        @(posedge clk); #1;
        i_valid = 1'b1; i_addr = 64'h8000_0004;
        req_q.push_back('{64'h8000_0004, 3'b010, 8'h00, 64'h0, 1});
        rd_q.push_back(64'h1111_2222_3333_4444);
        resp_q.push_back('{1'b0, 64'h1111_2222, cyc, 3});
        wait_ok(1, 20, "fetch");
        @(posedge clk); #1 i_valid = 1'b0;
        $display("[TB] fetch done, ok_count=%0d", ok_count);

        // Store with m_ready withheld four cycles
        ready_dly = 4;
        @(posedge clk); #1;
        d_valid = 1'b1; d_addr = 64'h8000_1000; d_size = 3'b011;
        d_strobe = 8'hFF; d_wdata = 64'hDEAD_BEEF_0000_0001;
        req_q.push_back('{64'h8000_1000, 3'b011, 8'hFF, 64'hDEAD_BEEF_0000_0001, 5});
        rd_q.push_back(64'h5A5A_5A5A_A5A5_A5A5);
        resp_q.push_back('{1'b1, 64'h5A5A_5A5A_A5A5_A5A5, cyc, 7});
        wait_ok(2, 30, "store");
        @(posedge clk); #1 d_valid = 1'b0;
        ready_dly = 0;
        $display("[TB] store done, ok_count=%0d", ok_count);

        // Reset during WAIT_RESP aborts the fetch
        mem_en = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b1; i_addr = 64'h100; m_ready = 1'b1;
        req_q.push_back('{64'h100, 3'b010, 8'h00, 64'h0, 1});
        @(posedge clk); #1;
        @(posedge clk); #1 m_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; i_valid = 1'b0;
        #1;
        tests++;
        if (all_out != '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %h, required 0", all_out);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        m_rvalid = 1'b1; m_rdata = 64'h9999_8888_7777_6666;
        @(posedge clk); #1 m_rvalid = 1'b0;
        repeat (3) @(negedge clk); #2;
        tests++;
        if (ok_count != 2 || m_valid || d_rdata != 64'h0) begin
            fails++;
            $display("FAIL reset_abort: ok_count=%0d m_valid=%0b d_rdata=%h, required 2 0 0",
                     ok_count, m_valid, d_rdata);
        end
        $display("[TB] reset abort done, ok_count=%0d", ok_count);

        // Spurious m_rvalid in IDLE
        @(posedge clk); #1;
        m_rvalid = 1'b1; m_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        @(posedge clk); #1 m_rvalid = 1'b0;
        repeat (3) @(negedge clk); #2;
        tests++;
        if (ok_count != 2 || m_valid || err || d_rdata != 64'h0 || i_data != 32'h0) begin
            fails++;
            $display("FAIL spurious_rvalid: ok_count=%0d m_valid=%0b err=%0b d_rdata=%h, required 2 0 0 0",
                     ok_count, m_valid, err, d_rdata);
        end
        $display("[TB] spurious rvalid done, ok_count=%0d", ok_count);

        // Both requesting continuously from reset: D, I, D, I
        mem_en = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b1; d_addr = 64'h2000; d_size = 3'b011; d_strobe = 8'h00; d_wdata = 64'h0;
        i_valid = 1'b1; i_addr = 64'h3000;
        req_q.push_back('{64'h2000, 3'b011, 8'h00, 64'h0, 1});
        req_q.push_back('{64'h3000, 3'b010, 8'h00, 64'h0, 1});
        req_q.push_back('{64'h2000, 3'b011, 8'h00, 64'h0, 1});
        req_q.push_back('{64'h3000, 3'b010, 8'h00, 64'h0, 1});
        rd_q.push_back(64'hA0A0_0000_D0D0_0001);
        rd_q.push_back(64'h1234_5678_9ABC_DEF0);
        rd_q.push_back(64'hD2D2_D2D2_0000_0002);
        rd_q.push_back(64'h0FED_CBA9_8765_4321);
        resp_q.push_back('{1'b1, 64'hA0A0_0000_D0D0_0001, cyc, 3});
        resp_q.push_back('{1'b0, 64'h9ABC_DEF0, cyc, 7});
        resp_q.push_back('{1'b1, 64'hD2D2_D2D2_0000_0002, cyc, 11});
        resp_q.push_back('{1'b0, 64'h8765_4321, cyc, 15});
        wait_ok(6, 40, "round_robin");
        @(posedge clk); #1;
        d_valid = 1'b0; i_valid = 1'b0;
        $display("[TB] round robin done, ok_count=%0d", ok_count);

        // Watchdog: m_rvalid withheld past TIMEOUT
        tests++;
        if (err) begin
            fails++;
            $display("FAIL err_pre_wdog: got %0b, required 0", err);
        end
        rvalid_dly = 20;
        @(posedge clk); #1;
        i_valid = 1'b1; i_addr = 64'h40;
        req_q.push_back('{64'h40, 3'b010, 8'h00, 64'h0, 1});
        rd_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        resp_q.push_back('{1'b0, 64'hCCCC_DDDD, cyc, 23});
        wait_ok(7, 60, "watchdog");
        @(posedge clk); #1 i_valid = 1'b0;
        repeat (2) @(negedge clk); #2;
        tests++;
        if (!err) begin
            fails++;
            $display("FAIL err_sticky: got %0b, required 1", err);
        end
        $display("[TB] watchdog done, ok_count=%0d err=%0b", ok_count, err);

        tests++;
        if (resp_q.size() != 0 || req_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: resp_q=%0d req_q=%0d, required 0 0", resp_q.size(), req_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
